// File: rtl/sumador_serial.sv
// Bit-serial adder: two Sumador2_2bits half-adder cells plus an OR form the per-bit full adder.
// A registered carry links the bits. Operands are processed LSB-first, one bit per clock.

module Sumador2_2bits (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);
    assign S = A ^ B;
    assign C = A & B;
endmodule

module sumador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_word;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             s1, c1, sb, c2;
    logic             last;

    Sumador2_2bits u_ha1 (.A(a_sh[0]), .B(b_sh[0]), .S(s1), .C(c1));
    Sumador2_2bits u_ha2 (.A(s1),      .B(cy),      .S(sb), .C(c2));

    // The incoming sum bit enters at the top, so after WIDTH steps the word is aligned.
    assign s_word = {sb, s_sh};
    assign last   = (state == ADD) && (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: the default assignment up front keeps this block from inferring a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ADD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            cnt  <= '0;
            cy   <= 1'b0;
            S    <= '0;
            C    <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        cy   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh <= s_word[WIDTH-1:1];
                    cy   <= c1 | c2;
                    if (last) begin
                        cnt  <= '0;
                        S    <= s_word;
                        C    <= c1 | c2;
                        done <= 1'b1;
                    end else begin
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: directed cases plus a randomized sweep,
// each compared against plain integer addition of the captured operands.

module tb_sumador_serial;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] S;
    logic         C;
    logic         busy;
    logic         done;

    int           asserts  = 0;
    int           failures = 0;
    logic [W-1:0] hold_s   = '0;
    logic         hold_c   = 1'b0;

    sumador_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .S(S), .C(C), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge right after the start edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts in the cycle after the start edge; returns in the done cycle.
    task automatic await_done(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit disturb);
        logic [W:0] expv = {1'b0, a} + {1'b0, b};
        int n = 0;
        int busy_n = 0;
        bit hold_ok = 1'b1;
        bit seen = 1'b0;
        while (n <= 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (S !== hold_s || C !== hold_c) hold_ok = 1'b0;
            if (disturb && n == 1) begin
                A = '0;
                B = '0;
                start = 1'b1;
            end
            if (disturb && n == 3) start = 1'b0;
            n++;
            @(negedge clk);
        end
        asserts++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles", name, n);
            return;
        end
        asserts++;
        if (n != W) begin
            failures++;
            $display("FAIL %s latency: done after %0d cycles, expected %0d", name, n, W);
        end
        asserts++;
        if (busy_n != W) begin
            failures++;
            $display("FAIL %s busy_len: %0d cycles, expected %0d", name, busy_n, W);
        end
        asserts++;
        if (!hold_ok) begin
            failures++;
            $display("FAIL %s hold: S/C changed while busy (expected %h/%b)", name, hold_s, hold_c);
        end
        asserts++;
        if ({C, S} !== expv) begin
            failures++;
            $display("FAIL %s result: {C,S}=%h, expected %h", name, {C, S}, expv);
        end
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done: busy=%b, expected 0", name, busy);
        end
        hold_s = expv[W-1:0];
        hold_c = expv[W];
    endtask

    task automatic check_cleared(input string name);
        asserts++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: done=%b one cycle later, expected 0", name, done);
        end
        asserts++;
        if (S !== hold_s || C !== hold_c) begin
            failures++;
            $display("FAIL %s after_done: S/C=%h/%b, expected %h/%b", name, S, C, hold_s, hold_c);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit disturb);
        issue(a, b);
        await_done(name, a, b, disturb);
        @(negedge clk);
        check_cleared(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (S !== '0 || C !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: S=%h C=%b busy=%b done=%b, expected all 0", S, C, busy, done);
        end
        hold_s = '0;
        hold_c = 1'b0;
    endtask

    task automatic test_basic();
        run_op("basic_05_03", 8'h05, 8'h03, 1'b0);
        run_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("ignore_aa_55", 8'hAA, 8'h55, 1'b1);
        repeat (3) @(negedge clk);
        asserts++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_restart: done=%b busy=%b after completion, expected 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(8'h80, 8'h80);
        await_done("b2b_first", 8'h80, 8'h80, 1'b0);
        issue(8'h7F, 8'h01);
        asserts++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_width: done=%b after second start, expected 0", done);
        end
        await_done("b2b_second", 8'h7F, 8'h01, 1'b0);
        @(negedge clk);
        check_cleared("b2b_second");
    endtask

    task automatic test_abort();
        bit pulsed = 1'b0;
        issue(8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_s = '0;
        hold_c = 1'b0;
        asserts++;
        if (S !== '0 || C !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: S=%h C=%b busy=%b done=%b, expected all 0", S, C, busy, done);
        end
        repeat (12) begin
            if (done !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
            @(negedge clk);
        end
        asserts++;
        if (pulsed) begin
            failures++;
            $display("FAIL abort_quiet: done or busy went high after abort, expected 0");
        end
        run_op("after_abort_10_20", 8'h10, 8'h20, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a = W'($urandom);
            logic [W-1:0] b = W'($urandom);
            run_op($sformatf("rand_%0d", i), a, b, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
